// File: rtl/scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with per-digit blanking window.
// Optional leading-zero blanking is compiled in with `define SCAN_LZB_EN.
module scan_driver #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic [3:0] CNT,
    output logic [1:0] SELECT,
    output logic [3:0] AN,
    output logic [6:0] SEG
);
    localparam int PW = $clog2(DIV);

    logic [PW-1:0] pcnt;
    logic [PW:0]   pcnt_p1;
    logic          wrap;
    logic          in_blank;
    logic [6:0]    seg_hex;
    logic          suppress;

    assign pcnt_p1  = {1'b0, pcnt} + (PW+1)'(1);
    assign wrap     = (pcnt == PW'(DIV - 1));
    // pcnt < BLANK-1, written without a subtraction that could underflow
    assign in_blank = (pcnt_p1 < (PW+1)'(BLANK));

    always_comb begin
        seg_hex = 7'b1111111;
        case (CNT)
            4'h0: seg_hex = 7'b1000000;
            4'h1: seg_hex = 7'b1111001;
            4'h2: seg_hex = 7'b0100100;
            4'h3: seg_hex = 7'b0110000;
            4'h4: seg_hex = 7'b0011001;
            4'h5: seg_hex = 7'b0010010;
            4'h6: seg_hex = 7'b0000010;
            4'h7: seg_hex = 7'b1111000;
            4'h8: seg_hex = 7'b0000000;
            4'h9: seg_hex = 7'b0010000;
            4'hA: seg_hex = 7'b0001000;
            4'hB: seg_hex = 7'b0000011;
            4'hC: seg_hex = 7'b1000110;
            4'hD: seg_hex = 7'b0100001;
            4'hE: seg_hex = 7'b0000110;
            4'hF: seg_hex = 7'b0001110;
            default: seg_hex = 7'b1111111;
        endcase
    end

`ifdef SCAN_LZB_EN
    logic [3:0] zf;
    logic       zf_above;
    logic       blank_end;

    assign blank_end = (pcnt_p1 == (PW+1)'(BLANK));

    // Higher digits' zero flags are from the previous frame; digit 0 always shows.
    always_comb begin
        zf_above = 1'b1;
        for (int j = 1; j < 4; j++) begin
            if (j > int'(SELECT)) zf_above = zf_above & zf[j];
        end
        suppress = (SELECT != 2'd0) && (CNT == 4'd0) && zf_above;
    end
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt   <= '0;
            SELECT <= 2'd0;
            AN     <= 4'b1111;
            SEG    <= 7'b1111111;
`ifdef SCAN_LZB_EN
            zf     <= 4'b1111;
`endif
        end else if (!ENABLE) begin
            AN  <= 4'b1111;
            SEG <= 7'b1111111;
        end else begin
            pcnt <= wrap ? '0 : pcnt + PW'(1);
            if (wrap) SELECT <= SELECT + 2'd1;
            if (in_blank || wrap) begin
                AN  <= 4'b1111;
                SEG <= 7'b1111111;
            end else begin
                AN  <= ~(4'b0001 << SELECT);
                SEG <= suppress ? 7'b1111111 : seg_hex;
            end
`ifdef SCAN_LZB_EN
            if (blank_end) zf[SELECT] <= (CNT == 4'd0);
`endif
        end
    end
endmodule

// File: tb/tb_scan_driver.sv
// Self-checking bench for scan_driver: directed scenarios plus random enable/reset/digit
// traffic, compared every cycle against a slot-arithmetic reference model.
module tb_scan_driver;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
`ifdef SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] cnt;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;

    logic [3:0] digits [4];
    logic [6:0] hexm [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int         tests = 0;
    int         fails = 0;
    int         mt    = 0;
    logic [3:0] lz    = 4'b1111;
    logic [1:0] e_sel;
    logic [3:0] e_an;
    logic [6:0] e_seg;

    scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .CLK(clk), .RST(rst), .ENABLE(enable), .CNT(cnt),
        .SELECT(sel), .AN(an), .SEG(seg)
    );

    // Behaves as the upstream 4:1 digit selector.
    assign cnt = digits[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mt counts enabled cycles since reset; slot = mt / DIV, digit = slot % 4.
    task automatic tick(input logic en, input logic r, input string tag);
        logic [3:0] dpre [4];
        int         dig;
        int         pos_post;
        logic [3:0] v;
        logic       above;
        logic       sup;
        enable = en;
        rst    = r;
        dpre   = digits;
        @(posedge clk);
        #1;
        if (r) begin
            mt    = 0;
            lz    = 4'b1111;
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end else if (!en) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end else begin
            dig      = (mt / DIV) % 4;
            mt       = mt + 1;
            pos_post = mt % DIV;
            if (pos_post < BLANK) begin
                e_an  = 4'b1111;
                e_seg = 7'b1111111;
            end else begin
                e_an  = ~(4'b0001 << dig);
                v     = dpre[dig];
                above = 1'b1;
                for (int j = dig + 1; j < 4; j++) above = above & lz[j];
                sup   = LZB && (dig != 0) && (v == 4'd0) && above;
                e_seg = sup ? 7'b1111111 : hexm[v];
                if (pos_post == BLANK) lz[dig] = (v == 4'd0);
            end
        end
        e_sel = 2'((mt / DIV) % 4);
        tests++;
        assert (sel === e_sel) else begin
            fails++;
            $error("FAIL %s sel t=%0t: got %b want %b", tag, $time, sel, e_sel);
        end
        tests++;
        assert (an === e_an) else begin
            fails++;
            $error("FAIL %s an t=%0t: got %b want %b", tag, $time, an, e_an);
        end
        tests++;
        assert (seg === e_seg) else begin
            fails++;
            $error("FAIL %s seg t=%0t: got %b want %b", tag, $time, seg, e_seg);
        end
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        digits[3] = d3;
        digits[2] = d2;
        digits[1] = d1;
        digits[0] = d0;
    endtask

    initial begin
        logic r;
        logic en;
        rst    = 1'b1;
        enable = 1'b1;
        set_digits(4'd5, 4'd5, 4'd5, 4'd5);

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, "reset");

        set_digits(4'hF, 4'hA, 4'h1, 4'h0);
        for (int i = 0; i < 5 * DIV; i++) tick(1'b1, 1'b0, "scan");

        tick(1'b1, 1'b1, "reset2");
        for (int i = 0; i < DIV + 4; i++) tick(1'b1, 1'b0, "pre_hold");
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "hold");
        for (int i = 0; i < 2 * DIV; i++) tick(1'b1, 1'b0, "resume");

        tick(1'b1, 1'b1, "reset3");
        for (int i = 0; i < 2 * DIV + 3; i++) tick(1'b1, 1'b0, "to_sel2");
        tick(1'b1, 1'b1, "mid_reset");
        for (int i = 0; i < 2 * DIV; i++) tick(1'b1, 1'b0, "restart");

        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        for (int i = 0; i < 8 * DIV; i++) tick(1'b1, 1'b0, "lzb_0005");
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 8 * DIV; i++) tick(1'b1, 1'b0, "lzb_0000");
        set_digits(4'd0, 4'd7, 4'd0, 4'd0);
        for (int i = 0; i < 8 * DIV; i++) tick(1'b1, 1'b0, "lzb_0700");

        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0)
                digits[$urandom_range(0, 3)] =
                    ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            tick(en, r, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
